sad_search_ctrl: RTL and testbench

Sequencer for the direct (non-pipelined) SAD `top_level` datapath during a block-matching search. On `start` it walks candidate blocks 0..N_CAND-1 in order. For each candidate it addresses the candidate buffer, launches one SAD computation through the core's `init`/`ack`/`done` handshake, and keeps a running minimum. It reports the best SAD and its candidate index to the motion-estimation layer above. The 32 original pixels are held stable by the upper layer for the whole search; this block does not touch them.

---
 rtl/sad_search_ctrl.sv | 148 ++++++++++++++
 tb/tb_sad_search_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_ctrl.sv
// Block-matching search sequencer: walks N_CAND candidates through one SAD core
// and reports the minimum SAD with its candidate index.
module sad_search_ctrl #(
  parameter int WIDTH   = 8,
  parameter int N_CAND  = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             res_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH+4:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic [IDX_W-1:0] cand_addr,
  output logic             sad_init,
  output logic             sad_ack,
  input  logic             sad_done,
  input  logic [WIDTH+4:0] sad_out,
  output logic [2:0]       dbg_state
);

  localparam int SW = WIDTH + 5;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_CMP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cand_addr_q, cand_addr_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [SW-1:0]    best_sad_q, best_sad_d;
  logic [SW-1:0]    cur_sad_q, cur_sad_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sad_init_q, sad_init_d;
  logic             sad_ack_q, sad_ack_d;

  // Core handshake: sad_init is a one-cycle launch pulse; the core then holds
  // sad_done (with sad_out valid) until it samples our one-cycle sad_ack.
  always_comb begin
    state_d     = state_q;
    cand_addr_d = cand_addr_q;
    best_idx_d  = best_idx_q;
    best_sad_d  = best_sad_q;
    cur_sad_d   = cur_sad_q;
    wdog_d      = wdog_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cand_addr_d = '0;
          best_idx_d  = '0;
          best_sad_d  = '1;
          err_d       = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH:  state_d = S_LAUNCH;
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sad_done) begin
          cur_sad_d = sad_out;
          state_d   = S_CMP;
        end else if (wdog_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_CMP: begin
        // Strict compare keeps the lower index on ties.
        if (cur_sad_q < best_sad_q) begin
          best_sad_d = cur_sad_q;
          best_idx_d = cand_addr_q;
        end
        if (cur_sad_q == '0) begin
          state_d = S_DONE;
        end else if (cand_addr_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          cand_addr_d = cand_addr_q + IDX_W'(1);
          state_d     = S_FETCH;
        end
      end
      S_DONE: begin
        if (res_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered, decoded from the state being entered.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    sad_init_d = (state_d == S_LAUNCH);
    sad_ack_d  = (state_d == S_CMP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cand_addr_q <= '0;
      best_idx_q  <= '0;
      best_sad_q  <= '1;
      cur_sad_q   <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sad_init_q  <= 1'b0;
      sad_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_addr_q <= cand_addr_d;
      best_idx_q  <= best_idx_d;
      best_sad_q  <= best_sad_d;
      cur_sad_q   <= cur_sad_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sad_init_q  <= sad_init_d;
      sad_ack_q   <= sad_ack_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign best_sad  = best_sad_q;
  assign best_idx  = best_idx_q;
  assign cand_addr = cand_addr_q;
  assign sad_init  = sad_init_q;
  assign sad_ack   = sad_ack_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: behavioural SAD core, vector table, hand-written
// corner sequences and randomized searches checked against a reference model.
module tb_sad_search_ctrl;

  localparam int NC = 4;
  localparam int TO = 16;
  localparam logic [12:0] ONES = 13'h1fff;

  logic        clk, rst, start, res_ack;
  logic        busy, done, err, sad_init, sad_ack, sad_done;
  logic [12:0] best_sad, sad_out;
  logic [3:0]  best_idx, cand_addr;
  logic [2:0]  dbg_state;

  sad_search_ctrl #(.WIDTH(8), .N_CAND(NC), .IDX_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .res_ack(res_ack),
    .busy(busy), .done(done), .err(err), .best_sad(best_sad),
    .best_idx(best_idx), .cand_addr(cand_addr), .sad_init(sad_init),
    .sad_ack(sad_ack), .sad_done(sad_done), .sad_out(sad_out),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural core ----------------
  logic [12:0] sad_tab [NC];
  int          core_lat;
  int          hang_idx;
  logic        core_busy, core_hung;
  int          core_cnt;

  always @(posedge clk) begin
    if (rst) begin
      core_busy <= 1'b0;
      core_hung <= 1'b0;
      core_cnt  <= 0;
      sad_done  <= 1'b0;
      sad_out   <= '0;
    end else begin
      if (sad_init) begin
        core_busy <= 1'b1;
        core_cnt  <= core_lat;
        sad_out   <= sad_tab[cand_addr[1:0]];
        core_hung <= (hang_idx == int'(cand_addr));
      end else if (core_busy && !core_hung) begin
        if (core_cnt <= 1) begin
          core_busy <= 1'b0;
          sad_done  <= 1'b1;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
      if (sad_ack) sad_done <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int         init_cnt = 0;
  int         ack_cnt = 0;
  int         proto_err = 0;
  logic       prev_done = 1'b0;
  logic [3:0] addr_log[$];

  always @(negedge clk) begin
    if (sad_init) begin
      init_cnt = init_cnt + 1;
      addr_log.push_back(cand_addr);
    end
    if (sad_ack) ack_cnt = ack_cnt + 1;
    if (sad_init && sad_ack) proto_err = proto_err + 1;
    if (sad_ack && !prev_done) proto_err = proto_err + 1;
    prev_done = sad_done;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Reference: plain walk over the candidate list using the search rules.
  task automatic ref_search(output logic [12:0] e_sad, output logic [3:0] e_idx,
                            output logic e_err, output int e_inits, output int e_acks,
                            output logic [3:0] e_addr, output int e_cyc);
    e_sad = ONES; e_idx = '0; e_err = 1'b0; e_inits = 0; e_acks = 0;
    e_addr = '0; e_cyc = 1;
    for (int i = 0; i < NC; i++) begin
      e_addr = 4'(i);
      e_inits++;
      if (i == hang_idx) begin
        e_err = 1'b1;
        e_cyc += 2 + TO;
        break;
      end
      e_acks++;
      e_cyc += core_lat + 4;
      if (sad_tab[i] < e_sad) begin
        e_sad = sad_tab[i];
        e_idx = 4'(i);
      end
      if (sad_tab[i] == 13'd0) break;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load(input logic [12:0] s0, s1, s2, s3, input int lat, input int hang);
    sad_tab[0] = s0; sad_tab[1] = s1; sad_tab[2] = s2; sad_tab[3] = s3;
    core_lat = lat; hang_idx = hang;
  endtask

  task automatic do_search(input bit poke, output int cyc, output bit ok);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc == 5);
    end
    start = 1'b0;
    ok = done;
  endtask

  task automatic finish_search(input string tag);
    @(posedge clk); #1 res_ack = 1'b1;
    @(posedge clk); #1 res_ack = 1'b0;
    chk({tag, "_busy_after_ack"}, busy, 0);
    chk({tag, "_done_after_ack"}, done, 0);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [12:0] e_sad, input logic [3:0] e_idx,
                           input logic e_err, input int e_inits, input int e_acks,
                           input logic [3:0] e_addr, input int e_cyc, input bit poke);
    int cyc, i0, a0, ab;
    bit ok, seq_ok;
    i0 = init_cnt; a0 = ack_cnt; ab = addr_log.size();
    do_search(poke, cyc, ok);
    chk({tag, "_done"}, ok, 1);
    chk({tag, "_best_sad"}, best_sad, e_sad);
    chk({tag, "_best_idx"}, best_idx, e_idx);
    chk({tag, "_err"}, err, e_err);
    chk({tag, "_cand_addr"}, cand_addr, e_addr);
    chk({tag, "_inits"}, init_cnt - i0, e_inits);
    chk({tag, "_acks"}, ack_cnt - a0, e_acks);
    chk({tag, "_cycles"}, cyc, e_cyc);
    seq_ok = (addr_log.size() == ab + e_inits);
    for (int j = 0; j < e_inits && seq_ok; j++)
      if (addr_log[ab + j] != 4'(j)) seq_ok = 1'b0;
    chk({tag, "_addr_seq"}, seq_ok, 1);
    if (ok) finish_search(tag);
    else pulse_rst();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [12:0] s0, s1, s2, s3;
    int          lat, hang;
    logic [12:0] e_sad;
    logic [3:0]  e_idx;
    logic        e_err;
    int          e_inits, e_acks;
    logic [3:0]  e_addr;
    int          e_cyc;
    bit          poke;
  } vec_t;

  vec_t vec [6];

  initial begin
    logic [12:0] m_sad;
    logic [3:0]  m_idx, m_addr;
    logic        m_err;
    int          m_inits, m_acks, m_cyc, base, n, a0;
    logic [12:0] rs [4];

    vec[0] = '{13'd40,   13'd12,   13'd30,   13'd12,   2, -1, 13'd12,   4'd1, 1'b0, 4, 4, 4'd3, 25, 1'b1};
    vec[1] = '{13'd500,  13'd0,    13'd7,    13'd3,    1, -1, 13'd0,    4'd1, 1'b0, 2, 2, 4'd1, 11, 1'b0};
    vec[2] = '{13'd8191, 13'd8191, 13'd8191, 13'd8191, 2, -1, 13'd8191, 4'd0, 1'b0, 4, 4, 4'd3, 25, 1'b0};
    vec[3] = '{13'd10,   13'd20,   13'd30,   13'd40,   2,  0, 13'd8191, 4'd0, 1'b1, 1, 0, 4'd0, 19, 1'b0};
    vec[4] = '{13'd5,    13'd9,    13'd3,    13'd3,    2,  3, 13'd3,    4'd2, 1'b1, 4, 3, 4'd3, 37, 1'b1};
    vec[5] = '{13'd100,  13'd200,  13'd300,  13'd50,   3, -1, 13'd50,   4'd3, 1'b0, 4, 4, 4'd3, 29, 1'b0};

    // ---- reset ----
    rst = 1'b1; start = 1'b0; res_ack = 1'b0;
    load(13'd0, 13'd0, 13'd0, 13'd0, 1, -1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sad_init", sad_init, 0);
    chk("rst_sad_ack", sad_ack, 0);
    chk("rst_cand_addr", cand_addr, 0);
    chk("rst_best_idx", best_idx, 0);
    chk("rst_best_sad", best_sad, ONES);
    rst = 1'b0;

    // ---- table ----
    for (int v = 0; v < 6; v++) begin
      load(vec[v].s0, vec[v].s1, vec[v].s2, vec[v].s3, vec[v].lat, vec[v].hang);
      run_check($sformatf("vec%0d", v), vec[v].e_sad, vec[v].e_idx, vec[v].e_err,
                vec[v].e_inits, vec[v].e_acks, vec[v].e_addr, vec[v].e_cyc, vec[v].poke);
    end

    // ---- reset during WAIT of candidate 2 ----
    load(13'd9, 13'd9, 13'd9, 13'd9, 3, -1);
    base = addr_log.size(); a0 = ack_cnt; n = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (addr_log.size() < base + 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_reached_cand2", addr_log.size(), base + 3);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_sad_init", sad_init, 0);
    chk("midrst_sad_ack", sad_ack, 0);
    chk("midrst_cand_addr", cand_addr, 0);
    chk("midrst_best_sad", best_sad, ONES);
    chk("midrst_best_idx", best_idx, 0);
    chk("midrst_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle", busy, 0);
    chk("midrst_no_ack", ack_cnt - a0, 2);

    // ---- start while in DONE, then start together with res_ack ----
    load(13'd40, 13'd12, 13'd30, 13'd12, 1, -1);
    begin
      int cyc;
      bit ok;
      do_search(1'b0, cyc, ok);
      chk("hold_done", ok, 1);
      for (int k = 0; k < 3; k++) begin
        start = 1'b1;
        @(posedge clk); #1;
      end
      start = 1'b0;
      chk("hold_still_done", done, 1);
      chk("hold_best_sad", best_sad, 13'd12);
      chk("hold_best_idx", best_idx, 1);
      start = 1'b1; res_ack = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; res_ack = 1'b0;
      chk("both_busy", busy, 0);
      chk("both_done", done, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("both_no_new_search", busy, 0);
    end

    // ---- randomized searches ----
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NC; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) rs[i] = 13'd0;
        else if (r < 5) rs[i] = 13'($urandom_range(1, 12));
        else rs[i] = 13'($urandom_range(0, 8191));
      end
      load(rs[0], rs[1], rs[2], rs[3], $urandom_range(1, 4),
           ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NC - 1)) : -1);
      ref_search(m_sad, m_idx, m_err, m_inits, m_acks, m_addr, m_cyc);
      run_check($sformatf("rnd%0d", it), m_sad, m_idx, m_err, m_inits, m_acks,
                m_addr, m_cyc, 1'($urandom_range(0, 1)));
    end

    chk("protocol_violations", proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
